// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: streaming RV32I instruction encoder with LUI+ADDI expansion of LI.
// Optional RV32I_ENC_RANGE_CHECK_EN rejects immediates that do not fit their encoding (err_code=10).
module rv32i_instr_encoder #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         op_sel,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [31:0]        imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, VALID, VALID_PEND} state_t;
    typedef enum logic [3:0] {F_LUI, F_AUIPC, F_JAL, F_JALR, F_BR, F_LD, F_ST, F_IMM, F_SH, F_R,
                              F_FENCE, F_ECALL, F_EBREAK, F_LI, F_ILL} fmt_t;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                           OPC_ST = 7'b0100011, OPC_IMM = 7'b0010011, OPC_R = 7'b0110011;
    state_t              r_state;
    logic [31:0]         r_out, r_pend;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [COUNT_W-1:0]  r_count;
    fmt_t                w_fmt;
    logic [2:0]          w_f3;
    logic                w_alt, w_fit12, w_two, w_range, w_reject, w_accept, w_out_fire;
    logic [19:0]         w_hi;
    logic [31:0]         w_word1, w_word2;
    logic [6:0]          w_f7;
    always_comb begin
        w_fmt = F_ILL;
        w_f3  = 3'd0;
        w_alt = 1'b0;
        case (op_sel)
            6'd0:  w_fmt = F_LUI;
            6'd1:  w_fmt = F_AUIPC;
            6'd2:  w_fmt = F_JAL;
            6'd3:  w_fmt = F_JALR;
            6'd4:  w_fmt = F_BR;
            6'd5:  begin w_fmt = F_BR; w_f3 = 3'd1; end
            6'd6:  begin w_fmt = F_BR; w_f3 = 3'd4; end
            6'd7:  begin w_fmt = F_BR; w_f3 = 3'd5; end
            6'd8:  begin w_fmt = F_BR; w_f3 = 3'd6; end
            6'd9:  begin w_fmt = F_BR; w_f3 = 3'd7; end
            6'd10: w_fmt = F_LD;
            6'd11: begin w_fmt = F_LD; w_f3 = 3'd1; end
            6'd12: begin w_fmt = F_LD; w_f3 = 3'd2; end
            6'd13: begin w_fmt = F_LD; w_f3 = 3'd4; end
            6'd14: begin w_fmt = F_LD; w_f3 = 3'd5; end
            6'd15: w_fmt = F_ST;
            6'd16: begin w_fmt = F_ST; w_f3 = 3'd1; end
            6'd17: begin w_fmt = F_ST; w_f3 = 3'd2; end
            6'd18: w_fmt = F_IMM;
            6'd19: begin w_fmt = F_IMM; w_f3 = 3'd2; end
            6'd20: begin w_fmt = F_IMM; w_f3 = 3'd3; end
            6'd21: begin w_fmt = F_IMM; w_f3 = 3'd4; end
            6'd22: begin w_fmt = F_IMM; w_f3 = 3'd6; end
            6'd23: begin w_fmt = F_IMM; w_f3 = 3'd7; end
            6'd24: begin w_fmt = F_SH; w_f3 = 3'd1; end
            6'd25: begin w_fmt = F_SH; w_f3 = 3'd5; end
            6'd26: begin w_fmt = F_SH; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd27: w_fmt = F_R;
            6'd28: begin w_fmt = F_R; w_alt = 1'b1; end
            6'd29: begin w_fmt = F_R; w_f3 = 3'd1; end
            6'd30: begin w_fmt = F_R; w_f3 = 3'd2; end
            6'd31: begin w_fmt = F_R; w_f3 = 3'd3; end
            6'd32: begin w_fmt = F_R; w_f3 = 3'd4; end
            6'd33: begin w_fmt = F_R; w_f3 = 3'd5; end
            6'd34: begin w_fmt = F_R; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd35: begin w_fmt = F_R; w_f3 = 3'd6; end
            6'd36: begin w_fmt = F_R; w_f3 = 3'd7; end
            6'd37: w_fmt = F_FENCE;
            6'd38: w_fmt = F_ECALL;
            6'd39: w_fmt = F_EBREAK;
            6'd40: w_fmt = F_LI;
            default: w_fmt = F_ILL;
        endcase
    end
    assign w_f7    = w_alt ? 7'b0100000 : 7'b0000000;
    assign w_fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    // LUI upper part is rounded up when the low 12 bits will sign-extend negative in ADDI
    assign w_hi    = imm[31:12] + {19'd0, imm[11]};
    always_comb begin
        w_word1 = '0;
        w_word2 = '0;
        w_two   = 1'b0;
        case (w_fmt)
            F_LUI:    w_word1 = {imm[31:12], rd, OPC_LUI};
            F_AUIPC:  w_word1 = {imm[31:12], rd, OPC_AUIPC};
            F_JAL:    w_word1 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            F_JALR:   w_word1 = {imm[11:0], rs1, w_f3, rd, OPC_JALR};
            F_BR:     w_word1 = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], OPC_BR};
            F_LD:     w_word1 = {imm[11:0], rs1, w_f3, rd, OPC_LD};
            F_ST:     w_word1 = {imm[11:5], rs2, rs1, w_f3, imm[4:0], OPC_ST};
            F_IMM:    w_word1 = {imm[11:0], rs1, w_f3, rd, OPC_IMM};
            F_SH:     w_word1 = {w_f7, imm[4:0], rs1, w_f3, rd, OPC_IMM};
            F_R:      w_word1 = {w_f7, rs2, rs1, w_f3, rd, OPC_R};
            F_FENCE:  w_word1 = 32'h0FF0000F;
            F_ECALL:  w_word1 = 32'h00000073;
            F_EBREAK: w_word1 = 32'h00100073;
            F_LI: begin
                w_word1 = w_fit12 ? {imm[11:0], 5'd0, 3'd0, rd, OPC_IMM} : {w_hi, rd, OPC_LUI};
                w_word2 = {imm[11:0], rd, 3'd0, rd, OPC_IMM};
                w_two   = !w_fit12 && (|imm[11:0]);
            end
            default:  w_word1 = '0;
        endcase
    end
`ifdef RV32I_ENC_RANGE_CHECK_EN
    logic w_fit13, w_fit21;
    assign w_fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fit21 = (&imm[31:20]) | ~(|imm[31:20]);
    assign w_range = ((w_fmt == F_LUI || w_fmt == F_AUIPC) && (|imm[11:0]))
                  || ((w_fmt == F_JALR || w_fmt == F_LD || w_fmt == F_ST || w_fmt == F_IMM) && !w_fit12)
                  || (w_fmt == F_BR && (!w_fit13 || imm[0]))
                  || (w_fmt == F_JAL && (!w_fit21 || imm[0]))
                  || (w_fmt == F_SH && (|imm[31:5]));
`else
    assign w_range = 1'b0;
`endif
    assign w_reject    = (w_fmt == F_ILL) || w_range;
    assign out_valid   = (r_state != IDLE);
    assign in_ready    = (r_state != VALID_PEND) && (!out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign out_instr   = r_out;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign instr_count = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_out      <= '0;
            r_pend     <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_count    <= '0;
        end else begin
            r_err <= w_accept && w_reject;
            if (w_accept && w_reject)
                r_err_code <= (w_fmt == F_ILL) ? 2'b01 : 2'b10;
            if (w_out_fire)
                r_count <= r_count + COUNT_W'(1);
            if (w_accept && !w_reject) begin
                r_out   <= w_word1;
                r_pend  <= w_word2;
                r_state <= w_two ? VALID_PEND : VALID;
            end else if (w_out_fire) begin
                r_out   <= (r_state == VALID_PEND) ? r_pend : r_out;
                r_state <= (r_state == VALID_PEND) ? VALID : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: directed plus random checks of rv32i_instr_encoder against an arithmetic reference encoder.
module tb_rv32i_instr_encoder;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [5:0]  op_sel = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        in_ready, out_valid, err;
    logic [31:0] out_instr, instr_count;
    logic [1:0]  err_code;
    int          n_cmp = 0, n_fail = 0;
    logic [31:0] q[$];
    logic [31:0] m_cnt = '0, m_code = '0, last_word = '0;

    rv32i_instr_encoder #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .err(err), .err_code(err_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ienc(input logic [31:0] im, r1, f3, rdd, opc);
        return ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdd << 7) | opc;
    endfunction

    // Reference: builds words by shifting and masking immediate fields, one word list per command.
    function automatic void ref_enc(input int op, input logic [31:0] r_d, r_s1, r_s2, im,
                                    output int n, output logic [31:0] w0, output logic [31:0] w1,
                                    output int ec);
        logic [31:0] br_f3 [6]  = '{0, 1, 4, 5, 6, 7};
        logic [31:0] ld_f3 [5]  = '{0, 1, 2, 4, 5};
        logic [31:0] im_f3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
        logic [31:0] r_f3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        logic [31:0] f7, hi;
        int s;
        bit rc;
        rc = 1'b0;
`ifdef RV32I_ENC_RANGE_CHECK_EN
        rc = 1'b1;
`endif
        s = $signed(im);
        n = 1; w0 = '0; w1 = '0; ec = 0;
        f7 = (op == 26 || op == 28 || op == 34) ? 32'h20 : 32'h0;
        if (op <= 1) begin
            w0 = (im & 32'hFFFFF000) | (r_d << 7) | ((op == 0) ? 32'h37 : 32'h17);
            if (rc && (im & 32'hFFF) != 0) ec = 2;
        end else if (op == 2) begin
            w0 = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
               | (((im >> 12) & 255) << 12) | (r_d << 7) | 32'h6F;
            if (rc && (s < -1048576 || s > 1048574 || im[0])) ec = 2;
        end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
            w0 = (op == 3) ? ienc(im, r_s1, 0, r_d, 32'h67)
               : (op <= 14) ? ienc(im, r_s1, ld_f3[op-10], r_d, 32'h03)
               : ienc(im, r_s1, im_f3[op-18], r_d, 32'h13);
            if (rc && (s < -2048 || s > 2047)) ec = 2;
        end else if (op <= 9) begin
            w0 = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (r_s2 << 20) | (r_s1 << 15)
               | (br_f3[op-4] << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
            if (rc && (s < -4096 || s > 4094 || im[0])) ec = 2;
        end else if (op <= 17) begin
            w0 = (((im >> 5) & 127) << 25) | (r_s2 << 20) | (r_s1 << 15) | ((op - 15) << 12)
               | ((im & 31) << 7) | 32'h23;
            if (rc && (s < -2048 || s > 2047)) ec = 2;
        end else if (op <= 26) begin
            w0 = (f7 << 25) | ((im & 31) << 20) | (r_s1 << 15) | (im_f3[op-18] << 12) | (r_d << 7) | 32'h13;
            if (rc && (s < 0 || s > 31)) ec = 2;
        end else if (op <= 36) begin
            w0 = (f7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (r_f3[op-27] << 12) | (r_d << 7) | 32'h33;
        end else if (op == 37) w0 = 32'h0FF0000F;
        else if (op == 38) w0 = 32'h00000073;
        else if (op == 39) w0 = 32'h00100073;
        else if (op == 40) begin
            if (s >= -2048 && s <= 2047) w0 = ienc(im, 0, 0, r_d, 32'h13);
            else begin
                hi = ((im >> 12) + ((im >> 11) & 1)) & 32'hFFFFF;
                w0 = (hi << 12) | (r_d << 7) | 32'h37;
                if ((im & 32'hFFF) != 0) begin
                    n = 2;
                    w1 = ienc(im, r_d, 0, r_d, 32'h13);
                end
            end
        end else ec = 1;
        if (ec != 0) n = 0;
    endfunction

    task automatic drive(input int op, r_d, r_s1, r_s2, input logic [31:0] im, input logic v, o);
        op_sel = 6'(op); rd = 5'(r_d); rs1 = 5'(r_s1); rs2 = 5'(r_s2);
        imm = im; in_valid = v; out_ready = o;
    endtask

    // One clock: entered just after a negedge with inputs set, returns at the next negedge.
    task automatic cyc();
        logic exp_rdy, fi, rej;
        int n, ec;
        logic [31:0] w0, w1;
        #1;
        exp_rdy = (q.size() < 2) && (q.size() == 0 || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        fi = in_valid && exp_rdy;
        rej = 1'b0;
        if (q.size() > 0 && out_ready) begin
            chk("out_instr", out_instr, q[0]);
            last_word = q.pop_front();
            m_cnt++;
        end
        if (fi) begin
            ref_enc(int'(op_sel), 32'(rd), 32'(rs1), 32'(rs2), imm, n, w0, w1, ec);
            if (ec != 0) begin rej = 1'b1; m_code = 32'(ec); end
            if (n >= 1) q.push_back(w0);
            if (n == 2) q.push_back(w1);
        end
        @(posedge clk);
        #1;
        chk("err", {31'd0, err}, {31'd0, rej});
        chk("err_code", {30'd0, err_code}, m_code);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("instr_count", instr_count, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        int op;
        logic [31:0] im;
        int sel;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // addi x1,x2,-1
        drive(18, 1, 2, 0, 32'hFFFFFFFF, 1, 1); cyc();
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        chk("addi_word", last_word, 32'hFFF10093);
        chk("addi_count", instr_count, 32'd1);
        // li x5,0x12345FFF with 3 cycles of backpressure
        drive(40, 5, 0, 0, 32'h12345FFF, 1, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("li_hold_word", out_instr, 32'h123462B7);
            chk("li_hold_ready", {31'd0, in_ready}, 32'd0);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        chk("li_lui", last_word, 32'h123462B7);
        cyc();
        chk("li_addi", last_word, 32'hFFF28293);
        chk("li_count", instr_count, 32'd3);
        // beq x1,x2,8
        drive(4, 0, 1, 2, 32'd8, 1, 1); cyc();
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        chk("beq_word", last_word, 32'h00208463);
`ifdef RV32I_ENC_RANGE_CHECK_EN
        drive(4, 0, 1, 2, 32'd7, 1, 1); cyc();
        chk("beq_odd_code", {30'd0, err_code}, 32'd2);
        chk("beq_odd_nov", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
`endif
        // illegal op_sel
        drive(45, 1, 1, 1, 0, 1, 1); cyc();
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_code", {30'd0, err_code}, 32'd1);
        chk("ill_count", instr_count, 32'd4);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        // back-to-back add x3,x1,x2
        drive(27, 3, 1, 2, 0, 1, 1);
        for (int i = 0; i < 6; i++) cyc();
        chk("add_word", last_word, 32'h002081B3);
        chk("add_count", instr_count, 32'd9);
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        // reset while the ADDI half of LI is pending
        drive(40, 7, 0, 0, 32'hABCDE123, 1, 0); cyc();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("rst_li_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_li_count", instr_count, 32'd0);
        q.delete();
        m_cnt = '0;
        m_code = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(41, 63)) : int'($urandom_range(0, 40));
            sel = int'($urandom_range(0, 3));
            im = (sel == 0) ? 32'($urandom_range(0, 4095)) - 32'd2048
               : (sel == 1) ? $urandom
               : (sel == 2) ? 32'($urandom_range(0, 40))
               : ($urandom & 32'hFFFFF000);
            drive(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  im, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Streaming RV32I encoder; it is the inverse of the instruction decoder.
- Accepts an operation select plus register and immediate fields over a valid/ready handshake.
- Emits the 32-bit instruction word over a valid/ready handshake.
- Expands the LI pseudo-op into LUI+ADDI with a two-word sequence.
- Used by the self-test program generator and the bench stimulus path that feeds fetch/decode.

Parameters:
- COUNT_W, 32, width of the emitted-instruction counter (wraps).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset; single clock domain.
- in_valid  in  1  command valid.
- in_ready  out  1  encoder can accept a command this cycle.
- op_sel  in  6  op code; mapping below.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  32  signed immediate or byte offset. For LUI/AUIPC it is the full value with the upper 20 bits used.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- err  out  1  one-cycle pulse: the last accepted command was rejected.
- err_code  out  2  01 illegal op_sel, 10 immediate out of range; holds its value until the next err pulse.
- instr_count  out  COUNT_W  count of out handshakes.

Behaviour:
- op_sel mapping:
  - 0 lui, 1 auipc, 2 jal, 3 jalr.
  - 4-9 beq, bne, blt, bge, bltu, bgeu.
  - 10-14 lb, lh, lw, lbu, lhu.
  - 15-17 sb, sh, sw.
  - 18-26 addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - 27-36 add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - 37 fence, 38 ecall, 39 ebreak, 40 li.
  - 41-63 illegal.
- Formats follow standard RV32I:
  - U: imm[31:12].
  - J/B: imm[20:1] / imm[12:1], standard bit scatter.
  - I/S: imm[11:0].
  - Shifts: shamt=imm[4:0]; funct7 is 0100000 for srai/sub/sra, else 0.
  - Fixed words: fence = 0x0FF0000F, ecall = 0x00000073, ebreak = 0x00100073.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state!=VALID_PEND) && (!out_valid || out_ready).
  - out_instr and out_valid are registered, so latency is accept to out_valid in 1 cycle.
  - While out_valid && !out_ready, out_instr is held stable.
- State machine:
  - IDLE: out_valid=0.
    - Accept of a legal single-word op goes to VALID.
    - Accept of a two-word LI goes to VALID_PEND.
    - Accept of a rejected op stays in IDLE and pulses err.
  - VALID:
    - Out handshake with no accept goes to IDLE.
    - Out handshake with a simultaneous accept loads the new word, same rules as IDLE.
    - No out handshake holds the state.
  - VALID_PEND:
    - out_instr is the LUI word; the ADDI word is held internally; in_ready=0.
    - Out handshake loads ADDI and goes to VALID.
- LI expansion:
  - If imm is in -2048..2047, emit a single ADDI rd,x0,imm.
  - Else hi = imm[31:12] + imm[11] (mod 2^20).
    - Emit LUI rd,hi.
    - Then ADDI rd,rd,imm[11:0], omitted when imm[11:0]==0.
- Rejected commands produce no output word, leave instr_count unchanged, and keep the state unchanged.
- instr_count increments on every out_valid && out_ready and wraps at 2^COUNT_W.
- Reset values:
  - out_valid=0, out_instr=0, err=0, err_code=0, instr_count=0, state IDLE.
  - A pending ADDI is discarded.
  - Reset mid-LI emits nothing further.

Optional Feature:
- Macro: RV32I_ENC_RANGE_CHECK_EN.
- Defined: commands are rejected with err_code=10 under these conditions:
  - I/S immediate outside -2048..2047.
  - B offset outside -4096..4094 or odd.
  - J offset outside -1048576..1048574 or odd.
  - Shift imm outside 0..31.
  - U imm[11:0]!=0.
- Undefined:
  - No range checks; fields are silently truncated to their encoded bits.
  - err_code=10 is never produced.
- Illegal op_sel is flagged with err_code=01 in both builds.

Test Plan:
- addi: op_sel=18, rd=1, rs1=2, imm=-1, out_ready=1 -> out_instr=0xFFF10093 one cycle after accept; instr_count=1.
- LI with backpressure: op_sel=40, rd=5, imm=0x12345FFF, out_ready low for 3 cycles -> out_instr=0x123462B7 held with in_ready=0; then 0xFFF28293; instr_count +2.
- beq: op_sel=4, rs1=1, rs2=2, imm=8 -> 0x00208463. Same command with imm=7 (RANGE_CHECK_EN) -> err pulse, err_code=10, no out_valid.
- Illegal op: op_sel=45 -> err=1 for one cycle, err_code=01, no output word, instr_count unchanged, in_ready stays 1.
- Back-to-back add: op_sel=27, rd=3, rs1=1, rs2=2 each cycle, out_ready=1 -> 0x002081B3 every cycle; in_ready stays 1; count increments by 1 per cycle.
- Reset mid-LI: assert rst in VALID_PEND -> next cycle out_valid=0, instr_count=0, and the ADDI word is never emitted.
